// File: rtl/seg7_pkg.sv
// Shared definitions for the sequential binary-to-7-segment converter:
// glyph constants, FSM state type and the digit-to-glyph lookup.
package seg7_pkg;

  // Active-high glyphs, bit 6 = segment a ... bit 0 = segment g
  localparam logic [6:0] ZERO  = 7'b1111110;
  localparam logic [6:0] ONE   = 7'b0110000;
  localparam logic [6:0] TWO   = 7'b1101101;
  localparam logic [6:0] THREE = 7'b1111001;
  localparam logic [6:0] FOUR  = 7'b0110011;
  localparam logic [6:0] FIVE  = 7'b1011011;
  localparam logic [6:0] SIX   = 7'b1011111;
  localparam logic [6:0] SEVEN = 7'b1110000;
  localparam logic [6:0] EIGHT = 7'b1111111;
  localparam logic [6:0] NINE  = 7'b1111011;
  localparam logic [6:0] BLANK = 7'b0000000;
  localparam logic [6:0] DASH  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ENCODE = 2'd2
  } state_t;

  // Decimal digit to active-high glyph; non-decimal codes render blank
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = ZERO;
      4'd1:    glyph = ONE;
      4'd2:    glyph = TWO;
      4'd3:    glyph = THREE;
      4'd4:    glyph = FOUR;
      4'd5:    glyph = FIVE;
      4'd6:    glyph = SIX;
      4'd7:    glyph = SEVEN;
      4'd8:    glyph = EIGHT;
      4'd9:    glyph = NINE;
      default: glyph = BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational glyph selection for one display position.
// Dash takes priority over blank, which takes priority over the digit.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  input  logic       active_low,
  output logic [6:0] glyph
);

  logic [6:0] glyph_high;

  // Pick the active-high glyph, then apply the display polarity
  always_comb begin
    glyph_high = digit_to_seg(digit);
    if (dash) begin
      glyph_high = DASH;
    end else if (blank) begin
      glyph_high = BLANK;
    end
    glyph = active_low ? ~glyph_high : glyph_high;
  end

endmodule

// File: rtl/bin_to_seg7_seq.sv
// Multi-cycle binary-to-BCD converter (one double-dabble step per clock)
// driving DIGITS seven-segment displays plus a sign display. The displays
// are only updated on the single ENCODE cycle, so they never tear.
module bin_to_seg7_seq
  import seg7_pkg::*;
#(
  parameter int W          = 8,
  parameter int DIGITS     = 3,
  parameter int SIGNED     = 0,
  parameter int ACTIVE_LOW = 0,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [W-1:0]          bus,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   seg,
  output logic [6:0]            sign_seg,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  // Blank glyph as seen on the pins for the chosen polarity
  localparam logic [6:0] BLANK_PIN = (ACTIVE_LOW != 0) ? ~BLANK : BLANK;

  state_t state;
  state_t state_next;

  logic [BW-1:0]        bcd;
  logic [BW-1:0]        bcd_adj;
  logic [W-1:0]         mag;
  logic [W-1:0]         mag_in;
  logic [CW-1:0]        count;
  logic                 neg;
  logic                 bus_neg;
  logic                 ovf_flag;
  logic                 sign_dash;
  logic [DIGITS-1:0]    blank;
  logic [7*DIGITS-1:0]  seg_comb;
  logic [6:0]           sign_comb;

  // Magnitude of the incoming value; the most negative code maps to 2^(W-1)
  assign bus_neg = (SIGNED != 0) && bus[W-1];
  assign mag_in  = bus_neg ? (~bus + 1'b1) : bus;

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: W shift steps, then one encode cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = SHIFT;
      SHIFT:   if (count == CW'(1)) state_next = ENCODE;
      ENCODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      // Add-3 correction so the following shift carries into the next digit
      assign bcd_adj[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ?
                                  (bcd[4*gi +: 4] + 4'd3) : bcd[4*gi +: 4];

      // A digit is a leading zero when it and everything above it are zero;
      // the units digit is always shown
      if (gi == 0) begin : g_units
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (BLANK_LZ != 0) && (bcd[BW-1:4*gi] == '0);
      end

      seg7_encode u_encode (
        .digit      (bcd[4*gi +: 4]),
        .blank      (blank[gi]),
        .dash       (ovf_flag),
        .active_low (ACTIVE_LOW != 0),
        .glyph      (seg_comb[7*gi +: 7])
      );
    end
  endgenerate

  // Sign display: minus only for a negative value that fits
  assign sign_dash = (SIGNED != 0) && neg && !ovf_flag;

  seg7_encode u_sign_encode (
    .digit      (4'hF),
    .blank      (1'b1),
    .dash       (sign_dash),
    .active_low (ACTIVE_LOW != 0),
    .glyph      (sign_comb)
  );

  // Conversion datapath: capture on start, shift-and-correct while in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd      <= '0;
      mag      <= '0;
      count    <= '0;
      neg      <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            bcd      <= '0;
            mag      <= mag_in;
            count    <= CW'(W);
            neg      <= bus_neg;
            ovf_flag <= 1'b0;
          end
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj[BW-2:0], mag, 1'b0};
          count      <= count - CW'(1);
          if (bcd_adj[BW-1]) begin
            ovf_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers: updated only on ENCODE, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg      <= {DIGITS{BLANK_PIN}};
      sign_seg <= BLANK_PIN;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ENCODE) begin
        seg      <= seg_comb;
        sign_seg <= sign_comb;
        ovf      <= ovf_flag;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_seg7_seq.sv
// Directed bench for bin_to_seg7_seq: five instances cover the default,
// no-blanking, signed, two-digit and active-low configurations.
module tb_bin_to_seg7_seq;
  import seg7_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // u0: defaults
  logic en0 = 1'b0, busy0, done0, ovf0;
  logic [7:0] bus0 = '0;
  logic [20:0] seg0;
  logic [6:0] sign0;
  // u1: no leading-zero blanking
  logic en1 = 1'b0, busy1, done1, ovf1;
  logic [7:0] bus1 = '0;
  logic [20:0] seg1;
  logic [6:0] sign1;
  // u2: signed
  logic en2 = 1'b0, busy2, done2, ovf2;
  logic [7:0] bus2 = '0;
  logic [20:0] seg2;
  logic [6:0] sign2;
  // u3: two digits
  logic en3 = 1'b0, busy3, done3, ovf3;
  logic [7:0] bus3 = '0;
  logic [13:0] seg3;
  logic [6:0] sign3;
  // u4: two digits, active-low
  logic en4 = 1'b0, busy4, done4, ovf4;
  logic [7:0] bus4 = '0;
  logic [13:0] seg4;
  logic [6:0] sign4;

  bin_to_seg7_seq u0 (.clk(clk), .rst_n(rst_n), .en(en0), .bus(bus0), .busy(busy0),
                      .done(done0), .seg(seg0), .sign_seg(sign0), .ovf(ovf0));
  bin_to_seg7_seq #(.BLANK_LZ(0)) u1 (.clk(clk), .rst_n(rst_n), .en(en1), .bus(bus1),
                      .busy(busy1), .done(done1), .seg(seg1), .sign_seg(sign1), .ovf(ovf1));
  bin_to_seg7_seq #(.SIGNED(1)) u2 (.clk(clk), .rst_n(rst_n), .en(en2), .bus(bus2),
                      .busy(busy2), .done(done2), .seg(seg2), .sign_seg(sign2), .ovf(ovf2));
  bin_to_seg7_seq #(.DIGITS(2)) u3 (.clk(clk), .rst_n(rst_n), .en(en3), .bus(bus3),
                      .busy(busy3), .done(done3), .seg(seg3), .sign_seg(sign3), .ovf(ovf3));
  bin_to_seg7_seq #(.DIGITS(2), .ACTIVE_LOW(1)) u4 (.clk(clk), .rst_n(rst_n), .en(en4),
                      .bus(bus4), .busy(busy4), .done(done4), .seg(seg4),
                      .sign_seg(sign4), .ovf(ovf4));

  function automatic logic done_of(input int idx);
    case (idx)
      0: return done0;
      1: return done1;
      2: return done2;
      3: return done3;
      default: return done4;
    endcase
  endfunction

  // Present a value with a one-cycle en; returns just after the accepting edge
  task automatic start(input int idx, input logic [7:0] val);
    case (idx)
      0: begin bus0 = val; en0 = 1'b1; end
      1: begin bus1 = val; en1 = 1'b1; end
      2: begin bus2 = val; en2 = 1'b1; end
      3: begin bus3 = val; en3 = 1'b1; end
      default: begin bus4 = val; en4 = 1'b1; end
    endcase
    @(posedge clk); #1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0; en4 = 1'b0;
  endtask

  // Edges after the accepting edge until done is seen; -1 on timeout
  task automatic wait_done(input int idx, output int edges);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done_of(idx)) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || ovf0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b ovf=%b expected 0 0 0", busy0, done0, ovf0);
    end
    checks++;
    if (seg0 !== {BLANK, BLANK, BLANK} || sign0 !== BLANK) begin
      failures++;
      $display("FAIL reset_seg seg=%h sign=%h expected all blank", seg0, sign0);
    end
    checks++;
    if (seg4 !== 14'h3FFF || sign4 !== 7'h7F) begin
      failures++;
      $display("FAIL reset_seg_active_low seg=%h sign=%h expected 3fff 7f", seg4, sign4);
    end
    $display("test_reset: outputs idle and blank");
  endtask

  task automatic test_latency_255();
    int busy_bad = 0;
    start(0, 8'd255);
    // cycles 1..9 after the en edge: busy, no done
    for (int i = 0; i < 9; i++) begin
      if (busy0 !== 1'b1 || done0 !== 1'b0) busy_bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL busy_window bad_cycles=%0d expected 0", busy_bad);
    end
    // cycle 10: done pulse with result
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle10 done=%b busy=%b expected 1 0", done0, busy0);
    end
    checks++;
    if (seg0 !== {TWO, FIVE, FIVE} || ovf0 !== 1'b0 || sign0 !== BLANK) begin
      failures++;
      $display("FAIL value_255 seg=%h ovf=%b sign=%h expected %h 0 00",
               seg0, ovf0, sign0, {TWO, FIVE, FIVE});
    end
    @(posedge clk); #1;
    checks++;
    if (done0 !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle done=%b expected 0", done0);
    end
    $display("test_latency_255: seg=%h", seg0);
  endtask

  task automatic test_blanking();
    int e;
    start(0, 8'd7); wait_done(0, e);
    checks++;
    if (e != 9 || seg0 !== {BLANK, BLANK, SEVEN}) begin
      failures++;
      $display("FAIL blank_7 edges=%0d seg=%h expected 9 %h", e, seg0, {BLANK, BLANK, SEVEN});
    end
    start(0, 8'd0); wait_done(0, e);
    checks++;
    if (e != 9 || seg0 !== {BLANK, BLANK, ZERO}) begin
      failures++;
      $display("FAIL blank_0 edges=%0d seg=%h expected 9 %h", e, seg0, {BLANK, BLANK, ZERO});
    end
    start(1, 8'd7); wait_done(1, e);
    checks++;
    if (e != 9 || seg1 !== {ZERO, ZERO, SEVEN}) begin
      failures++;
      $display("FAIL noblank_7 edges=%0d seg=%h expected 9 %h", e, seg1, {ZERO, ZERO, SEVEN});
    end
    $display("test_blanking: 7/0 blanked, 7 unblanked=%h", seg1);
  endtask

  task automatic test_signed();
    int e;
    start(2, 8'h80); wait_done(2, e);
    checks++;
    if (e != 9 || sign2 !== DASH || seg2 !== {ONE, TWO, EIGHT} || ovf2 !== 1'b0) begin
      failures++;
      $display("FAIL signed_min edges=%0d sign=%h seg=%h ovf=%b expected 9 01 %h 0",
               e, sign2, seg2, ovf2, {ONE, TWO, EIGHT});
    end
    start(2, 8'h7F); wait_done(2, e);
    checks++;
    if (e != 9 || sign2 !== BLANK || seg2 !== {ONE, TWO, SEVEN}) begin
      failures++;
      $display("FAIL signed_max edges=%0d sign=%h seg=%h expected 9 00 %h",
               e, sign2, seg2, {ONE, TWO, SEVEN});
    end
    start(2, 8'hFF); wait_done(2, e);
    checks++;
    if (e != 9 || sign2 !== DASH || seg2 !== {BLANK, BLANK, ONE}) begin
      failures++;
      $display("FAIL signed_m1 edges=%0d sign=%h seg=%h expected 9 01 %h",
               e, sign2, seg2, {BLANK, BLANK, ONE});
    end
    $display("test_signed: -128, 127, -1 converted");
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int e;
    logic [20:0] prev;
    prev = seg0;
    start(0, 8'd42);             // just after accept edge N
    @(posedge clk); #1;
    @(posedge clk); #1;          // after N+2
    checks++;
    if (seg0 !== prev) begin
      failures++;
      $display("FAIL hold_while_busy seg=%h expected %h", seg0, prev);
    end
    bus0 = 8'd99; en0 = 1'b1;    // sampled at N+3 while busy: ignored
    @(posedge clk); #1;
    en0 = 1'b0;
    // from N+3 to N+9 inclusive: done only at N+9
    for (int i = 0; i < 6; i++) begin
      if (done0 === 1'b1) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 0 || done0 !== 1'b1 || seg0 !== {BLANK, FOUR, TWO}) begin
      failures++;
      $display("FAIL ignore_busy_en early_dones=%0d done=%b seg=%h expected 0 1 %h",
               dones, done0, seg0, {BLANK, FOUR, TWO});
    end
    // new request on the done cycle is accepted
    start(0, 8'd99);
    wait_done(0, e);
    checks++;
    if (e != 9 || seg0 !== {BLANK, NINE, NINE}) begin
      failures++;
      $display("FAIL en_on_done edges=%0d seg=%h expected 9 %h", e, seg0, {BLANK, NINE, NINE});
    end
    $display("test_back_to_back: 42 then 99 seg=%h", seg0);
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int e;
    start(0, 8'd255);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;          // inside cycle 4 of the conversion
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || seg0 !== {BLANK, BLANK, BLANK} ||
        sign0 !== BLANK || ovf0 !== 1'b0) begin
      failures++;
      $display("FAIL abort_blank busy=%b done=%b seg=%h sign=%h ovf=%b expected 0 0 0 0 0",
               busy0, done0, seg0, sign0, ovf0);
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1 || busy0 === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done active_cycles=%0d expected 0", dones);
    end
    start(0, 8'd123); wait_done(0, e);
    checks++;
    if (e != 9 || seg0 !== {ONE, TWO, THREE}) begin
      failures++;
      $display("FAIL after_abort_123 edges=%0d seg=%h expected 9 %h", e, seg0, {ONE, TWO, THREE});
    end
    $display("test_reset_abort: 123 seg=%h", seg0);
  endtask

  task automatic test_overflow_polarity();
    int e;
    start(3, 8'd100); wait_done(3, e);
    checks++;
    if (e != 9 || ovf3 !== 1'b1 || seg3 !== {DASH, DASH} || sign3 !== BLANK) begin
      failures++;
      $display("FAIL ovf_100 edges=%0d ovf=%b seg=%h sign=%h expected 9 1 %h 00",
               e, ovf3, seg3, sign3, {DASH, DASH});
    end
    start(3, 8'd99); wait_done(3, e);
    checks++;
    if (e != 9 || ovf3 !== 1'b0 || seg3 !== {NINE, NINE}) begin
      failures++;
      $display("FAIL fit_99 edges=%0d ovf=%b seg=%h expected 9 0 %h", e, ovf3, seg3, {NINE, NINE});
    end
    start(4, 8'd5); wait_done(4, e);
    checks++;
    if (e != 9 || seg4 !== 14'b1111111_0100100 || sign4 !== 7'b1111111 || ovf4 !== 1'b0) begin
      failures++;
      $display("FAIL active_low_5 edges=%0d seg=%b sign=%b ovf=%b expected 9 11111110100100 1111111 0",
               e, seg4, sign4, ovf4);
    end
    $display("test_overflow_polarity: ovf3=%b seg4=%b", ovf3, seg4);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_latency_255();
    test_blanking();
    test_signed();
    test_back_to_back();
    test_reset_abort();
    test_overflow_polarity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
